// File: rtl/calc_pkg.sv
// Shared types and key codes for the keypad-to-adder sequencing controller.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ADD_REQ = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_PLUS = 4'd10;
    localparam logic [3:0] KEY_EQ   = 4'd11;
    localparam logic [3:0] KEY_CLR  = 4'd12;

endpackage

// File: rtl/digit_accumulator.sv
// Builds one decimal operand digit by digit; refuses digits once DIGITS have been taken.
module digit_accumulator #(
    parameter int DIGITS = 3,
    parameter int OP_W   = 10,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load_d,
    input  logic [3:0]       d,
    output logic [OP_W-1:0]  acc,
    output logic [CNT_W-1:0] cnt,
    output logic             full
);

    logic [OP_W-1:0] acc_x10;
    logic [OP_W-1:0] d_ext;

    // The digit limit keeps acc*10+d inside OP_W bits, so no saturation is needed.
    assign acc_x10 = (acc << 3) + (acc << 1);
    assign d_ext   = OP_W'(d);
    assign full    = (cnt == CNT_W'(DIGITS));

    // clr together with load_d starts a fresh operand holding the single digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            if (load_d) begin
                acc <= d_ext;
                cnt <= CNT_W'(1);
            end else begin
                acc <= '0;
                cnt <= '0;
            end
        end else if (load_d && !full) begin
            acc <= acc_x10 + d_ext;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_sum_ctrl.sv
// Sequences keypad events into two operands, requests one addition, and holds the sum for display.
module keypad_sum_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int OP_W   = 10,
    parameter int RES_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             add_ack,
    input  logic [RES_W-1:0] add_sum,
    output logic             add_req,
    output logic [OP_W-1:0]  operand_a,
    output logic [OP_W-1:0]  operand_b,
    output logic [RES_W-1:0] result,
    output logic [RES_W-1:0] disp_value,
    output logic [1:0]       state_o,
    output logic             entry_err
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    state_t state, next_state;

    logic             clr_a, load_a, clr_b, load_b;
    logic             res_load, res_clr, err_next;
    logic [OP_W-1:0]  acc_a, acc_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             full_a, full_b;
    logic             is_digit, is_plus, is_eq, is_clr;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_plus  = key_valid && (key_code == KEY_PLUS);
    assign is_eq    = key_valid && (key_code == KEY_EQ);
    assign is_clr   = key_valid && (key_code == KEY_CLR);

    digit_accumulator #(.DIGITS(DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_acc_a (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_a),
        .load_d (load_a),
        .d      (key_code),
        .acc    (acc_a),
        .cnt    (cnt_a),
        .full   (full_a)
    );

    digit_accumulator #(.DIGITS(DIGITS), .OP_W(OP_W), .CNT_W(CNT_W)) u_acc_b (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_b),
        .load_d (load_b),
        .d      (key_code),
        .acc    (acc_b),
        .cnt    (cnt_b),
        .full   (full_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTER_A;
            result    <= '0;
            entry_err <= 1'b0;
        end else begin
            state     <= next_state;
            entry_err <= err_next;
            if (res_clr)
                result <= '0;
            else if (res_load)
                result <= add_sum;
        end
    end

    // ADD_REQ only listens to add_ack, so keys (even CLEAR) cannot disturb frozen operands.
    always_comb begin
        next_state = state;
        clr_a      = 1'b0;
        load_a     = 1'b0;
        clr_b      = 1'b0;
        load_b     = 1'b0;
        res_load   = 1'b0;
        res_clr    = 1'b0;
        err_next   = 1'b0;
        case (state)
            ENTER_A: begin
                if (is_clr) begin
                    clr_a   = 1'b1;
                    clr_b   = 1'b1;
                    res_clr = 1'b1;
                end else if (is_digit) begin
                    load_a   = !full_a;
                    err_next = full_a;
                end else if (is_plus && (cnt_a != '0)) begin
                    clr_b      = 1'b1;
                    next_state = ENTER_B;
                end
            end
            ENTER_B: begin
                if (is_clr) begin
                    clr_a      = 1'b1;
                    clr_b      = 1'b1;
                    res_clr    = 1'b1;
                    next_state = ENTER_A;
                end else if (is_digit) begin
                    load_b   = !full_b;
                    err_next = full_b;
                end else if (is_eq && (cnt_b != '0)) begin
                    next_state = ADD_REQ;
                end
            end
            ADD_REQ: begin
                if (add_ack) begin
                    res_load   = 1'b1;
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (is_clr || is_digit) begin
                    clr_a      = 1'b1;
                    load_a     = is_digit;
                    clr_b      = 1'b1;
                    res_clr    = 1'b1;
                    next_state = ENTER_A;
                end
            end
            default: next_state = ENTER_A;
        endcase
    end

    // B stays on display through the request so the user sees the last operand typed.
    always_comb begin
        disp_value = '0;
        case (state)
            ENTER_A:          disp_value = RES_W'(acc_a);
            ENTER_B, ADD_REQ: disp_value = RES_W'(acc_b);
            SHOW:             disp_value = result;
            default:          disp_value = '0;
        endcase
    end

    assign add_req   = (state == ADD_REQ);
    assign operand_a = acc_a;
    assign operand_b = acc_b;
    assign state_o   = state;

endmodule

// File: tb/tb_keypad_sum_ctrl.sv
// Directed bench for keypad_sum_ctrl with hand-computed expectations.
module tb_keypad_sum_ctrl;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        add_ack;
    logic [10:0] add_sum;
    logic        add_req;
    logic [9:0]  operand_a;
    logic [9:0]  operand_b;
    logic [10:0] result;
    logic [10:0] disp_value;
    logic [1:0]  state_o;
    logic        entry_err;

    int checks   = 0;
    int failures = 0;

    keypad_sum_ctrl #(.DIGITS(3), .OP_W(10), .RES_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .add_ack    (add_ack),
        .add_sum    (add_sum),
        .add_req    (add_req),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .disp_value (disp_value),
        .state_o    (state_o),
        .entry_err  (entry_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle key pulse; returns on the negedge after the accepting posedge.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic pulseAck(input logic [10:0] sum);
        @(negedge clk);
        add_ack = 1'b1;
        add_sum = sum;
        @(negedge clk);
        add_ack = 1'b0;
        add_sum = '0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = '0; add_ack = 1'b0; add_sum = '0;
        #1;
        checkOutput("rst_state",  32'(state_o),    0);
        checkOutput("rst_req",    32'(add_req),    0);
        checkOutput("rst_a",      32'(operand_a),  0);
        checkOutput("rst_b",      32'(operand_b),  0);
        checkOutput("rst_result", 32'(result),     0);
        checkOutput("rst_disp",   32'(disp_value), 0);
        checkOutput("rst_err",    32'(entry_err),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 12 + 34 with ack in the third request cycle
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        checkOutput("a12_disp", 32'(disp_value), 12);
        applyStimulus(KEY_PLUS);
        checkOutput("plus_state", 32'(state_o), 1);
        applyStimulus(4'd3);
        applyStimulus(4'd4);
        checkOutput("b34_disp", 32'(disp_value), 34);
        applyStimulus(KEY_EQ);
        checkOutput("req_cyc1",  32'(add_req),   1);
        checkOutput("req_state", 32'(state_o),   2);
        checkOutput("req_a",     32'(operand_a), 12);
        checkOutput("req_b",     32'(operand_b), 34);
        checkOutput("req_disp",  32'(disp_value), 34);
        @(negedge clk);
        checkOutput("req_cyc2", 32'(add_req), 1);
        @(negedge clk);
        checkOutput("req_cyc3", 32'(add_req), 1);
        add_ack = 1'b1; add_sum = 11'd46;
        @(negedge clk);
        add_ack = 1'b0; add_sum = '0;
        checkOutput("ack_req",    32'(add_req),    0);
        checkOutput("ack_result", 32'(result),     46);
        checkOutput("ack_disp",   32'(disp_value), 46);
        checkOutput("ack_state",  32'(state_o),    3);

        // Digit from SHOW starts a new calculation
        applyStimulus(4'd7);
        checkOutput("show7_state",  32'(state_o),    0);
        checkOutput("show7_a",      32'(operand_a),  7);
        checkOutput("show7_b",      32'(operand_b),  0);
        checkOutput("show7_result", 32'(result),     0);
        checkOutput("show7_disp",   32'(disp_value), 7);
        applyStimulus(KEY_CLR);

        // Digit limit
        applyStimulus(4'd9);
        applyStimulus(4'd9);
        applyStimulus(4'd9);
        checkOutput("999_err_low", 32'(entry_err), 0);
        applyStimulus(4'd9);
        checkOutput("999_err_pulse", 32'(entry_err), 1);
        checkOutput("999_a",         32'(operand_a), 999);
        checkOutput("999_cnt",       32'(dut.u_acc_a.cnt), 3);
        @(negedge clk);
        checkOutput("999_err_gone", 32'(entry_err), 0);
        applyStimulus(KEY_CLR);
        checkOutput("clr_a", 32'(operand_a), 0);

        // PLUS / EQUALS / code 14 with no digits
        applyStimulus(KEY_PLUS);
        applyStimulus(KEY_EQ);
        applyStimulus(4'd14);
        checkOutput("empty_state", 32'(state_o),    0);
        checkOutput("empty_disp",  32'(disp_value), 0);

        // CLEAR from ENTER_B
        applyStimulus(4'd5);
        applyStimulus(KEY_PLUS);
        applyStimulus(4'd6);
        checkOutput("b6_disp", 32'(disp_value), 6);
        applyStimulus(KEY_CLR);
        checkOutput("clrb_a",     32'(operand_a),  0);
        checkOutput("clrb_b",     32'(operand_b),  0);
        checkOutput("clrb_state", 32'(state_o),    0);
        checkOutput("clrb_disp",  32'(disp_value), 0);

        // Keys ignored during the request
        applyStimulus(4'd2);
        applyStimulus(KEY_PLUS);
        applyStimulus(4'd8);
        applyStimulus(KEY_EQ);
        applyStimulus(4'd3);
        checkOutput("hold_a3", 32'(operand_a), 2);
        checkOutput("hold_b3", 32'(operand_b), 8);
        applyStimulus(KEY_CLR);
        checkOutput("hold_clr_state", 32'(state_o),   2);
        checkOutput("hold_clr_a",     32'(operand_a), 2);
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'd5; add_ack = 1'b1; add_sum = 11'd10;
        @(negedge clk);
        key_valid = 1'b0; key_code = '0; add_ack = 1'b0; add_sum = '0;
        checkOutput("coinc_state",  32'(state_o),   3);
        checkOutput("coinc_result", 32'(result),    10);
        checkOutput("coinc_a",      32'(operand_a), 2);
        checkOutput("coinc_b",      32'(operand_b), 8);
        pulseAck(11'd99);
        checkOutput("stray_ack_result", 32'(result), 10);

        // Reset during the handshake, then a late ack
        applyStimulus(KEY_CLR);
        applyStimulus(4'd4);
        applyStimulus(KEY_PLUS);
        applyStimulus(4'd5);
        applyStimulus(KEY_EQ);
        checkOutput("pre_rst_req", 32'(add_req), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_req",    32'(add_req),    0);
        checkOutput("mid_rst_a",      32'(operand_a),  0);
        checkOutput("mid_rst_b",      32'(operand_b),  0);
        checkOutput("mid_rst_state",  32'(state_o),    0);
        checkOutput("mid_rst_disp",   32'(disp_value), 0);
        @(negedge clk);
        rst = 1'b0;
        pulseAck(11'd77);
        checkOutput("late_ack_result", 32'(result),  0);
        checkOutput("late_ack_state",  32'(state_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
